// File: rtl/image_enhance.sv
// -----------------------------------------------------------------------------
// image_enhance
//   Streaming per-pixel RGB enhancement stage between the pixel source and the
//   BMP sink. Applies one of four modes: pass-through, saturating brightness
//   add/subtract, invert, or gray threshold. It uses a two-stage valid/ready
//   pipeline and tracks the output pixel position so it can flag end-of-line
//   and end-of-frame.
//
//   Parameters
//     WIDTH      pixels per line (>=2)
//     HEIGHT     lines per frame (>=1)
//     MODE       0=pass, 1=brightness, 2=invert, 3=threshold
//     VALUE      brightness offset 0..255 (MODE 1)
//     SIGN       1=add VALUE, 0=subtract VALUE (MODE 1)
//     THRESHOLD  gray threshold 0..255 (MODE 3)
//
//   Ports
//     clk, reset                        rising-edge clock, async active-high reset
//     in_valid / in_ready               input handshake
//     in_red / in_green / in_blue       input pixel
//     out_valid / out_ready             output handshake
//     out_red / out_green / out_blue    enhanced pixel
//     out_eol                           current output pixel ends its line
//     frame_done                        one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module image_enhance #(
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 512,
  parameter int MODE      = 1,
  parameter int VALUE     = 100,
  parameter int SIGN      = 1,
  parameter int THRESHOLD = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue,
  output logic       out_eol,
  output logic       frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [8:0]    VAL9     = 9'(VALUE);
  localparam logic [9:0]    THR3     = 10'(3 * THRESHOLD);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  logic          advance;
  logic          s1_valid;
  pixel_t        s1_px;
  pixel_t        s1_res;
  logic          s2_valid;
  pixel_t        s2_px;
  logic [9:0]    gray_sum;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_hs;

  // Saturating brightness on one channel. The 9-bit sum's carry and the
  // 9-bit signed difference's sign bit select the clamp value.
  function automatic logic [7:0] brighten(input logic [7:0] c);
    logic [8:0]        sum;
    logic signed [8:0] diff;
    sum  = {1'b0, c} + VAL9;
    diff = $signed({1'b0, c}) - $signed(VAL9);
    if (SIGN != 0) return sum[8] ? 8'hFF : sum[7:0];
    else           return diff[8] ? 8'h00 : diff[7:0];
  endfunction

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance  = !s2_valid || out_ready;
  assign in_ready = advance;
  assign out_hs   = s2_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    s1_res   = s1_px;
    gray_sum = 10'(s1_px.r) + 10'(s1_px.g) + 10'(s1_px.b);
    if (MODE == 1) begin
      s1_res.r = brighten(s1_px.r);
      s1_res.g = brighten(s1_px.g);
      s1_res.b = brighten(s1_px.b);
    end else if (MODE == 2) begin
      s1_res = {~s1_px.r, ~s1_px.g, ~s1_px.b};
    end else if (MODE == 3) begin
      // Strict compare: a sum equal to 3*THRESHOLD maps to black.
      s1_res = (gray_sum > THR3) ? '1 : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: pixel data registers are cleared along with the valids so the
      // outputs read 0 after reset; a bulk pixel memory would not be reset.
      s1_valid <= 1'b0;
      s1_px    <= '0;
      s2_valid <= 1'b0;
      s2_px    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_px    <= {in_red, in_green, in_blue};
      s2_valid <= s1_valid;
      s2_px    <= s1_res;
    end
  end

  // Position of the pixel currently held in S2; it moves on output handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && (col == COL_LAST) && (row == ROW_LAST);
      if (out_hs) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_red   = s2_px.r;
  assign out_green = s2_px.g;
  assign out_blue  = s2_px.b;
  assign out_eol   = s2_valid && (col == COL_LAST);

endmodule

// File: tb/tb_image_enhance.sv
// -----------------------------------------------------------------------------
// tb_image_enhance
//   Five instances of image_enhance share one input stream and one out_ready:
//   0 brighten +100, 1 darken -100, 2 invert, 3 threshold 90, 4 threshold 255.
//   All use WIDTH=4, HEIGHT=2 so line/frame flags show up quickly. A negedge
//   monitor pushes expected results on each input handshake and pops/compares
//   them on each output handshake.
// -----------------------------------------------------------------------------
module tb_image_enhance;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = 5;

  typedef struct packed {
    logic [N-1:0][23:0] rgb;
    logic               eol;
  } exp_t;

  typedef struct packed {
    logic [7:0]         r;
    logic [7:0]         g;
    logic [7:0]         b;
    logic [N-1:0][23:0] rgb;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_red, in_green, in_blue;
  logic          out_ready;
  logic [N-1:0]  in_ready, out_valid, out_eol, frame_done;
  logic [7:0]    out_red [N];
  logic [7:0]    out_green [N];
  logic [7:0]    out_blue [N];

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t cur;
  int   in_idx = 0;
  int   out_idx = 0;
  int   fd_pulses = 0;
  logic fd_exp = 1'b0;
  logic prev_stall = 1'b0;
  logic [25:0] prev_out = '0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    image_enhance #(
      .WIDTH(W), .HEIGHT(H),
      .MODE((i == 2) ? 2 : (i >= 3) ? 3 : 1),
      .VALUE(100),
      .SIGN((i == 1) ? 0 : 1),
      .THRESHOLD((i == 4) ? 255 : 90)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready[i]),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .out_valid(out_valid[i]), .out_ready(out_ready),
      .out_red(out_red[i]), .out_green(out_green[i]), .out_blue(out_blue[i]),
      .out_eol(out_eol[i]), .frame_done(frame_done[i])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [23:0] px(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic vec_t mkv(input int r, input int g, input int b,
                               input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3,
                               input logic [23:0] e4);
    vec_t v;
    v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
    v.rgb = {e4, e3, e2, e1, e0};
    return v;
  endfunction

  // Reference model for random pixels, written with plain integer math.
  function automatic logic [N-1:0][23:0] model(input int r, input int g, input int b);
    int c[3];
    int a[3], s[3], v[3];
    int sum;
    logic [N-1:0][23:0] e;
    c = '{r, g, b};
    for (int k = 0; k < 3; k++) begin
      a[k] = (c[k] + 100 > 255) ? 255 : c[k] + 100;
      s[k] = (c[k] < 100) ? 0 : c[k] - 100;
      v[k] = 255 - c[k];
    end
    sum  = r + g + b;
    e[0] = px(a[0], a[1], a[2]);
    e[1] = px(s[0], s[1], s[2]);
    e[2] = px(v[0], v[1], v[2]);
    e[3] = (sum > 270) ? 24'hFFFFFF : 24'h0;
    e[4] = (sum > 765) ? 24'hFFFFFF : 24'h0;
    return e;
  endfunction

  // Call aligned #1 after a rising edge; returns aligned the same way.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [N-1:0][23:0] e);
    int   budget = 0;
    logic ok;
    in_valid = 1'b1;
    in_red = r; in_green = g; in_blue = b;
    cur.rgb = e;
    do begin
      @(negedge clk);
      ok = in_ready[0];
      @(posedge clk); #1;
      budget++;
    end while (!ok && budget < 100);
    if (!ok) fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [7:0] r, g, b;
    r = 8'($urandom_range(0, 255));
    g = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    send(r, g, b, model(int'(r), int'(g), int'(b)));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) fail("drain_timeout");
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      in_idx = 0;
      out_idx = 0;
      fd_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        check($sformatf("frame_done_dut%0d", i), 32'(frame_done[i]), 32'(fd_exp));
      if (frame_done[0]) fd_pulses++;
      if (prev_stall)
        check("stall_hold", 32'({out_valid[0], out_eol[0], out_red[0], out_green[0], out_blue[0]}),
              32'(prev_out));
      fd_exp = 1'b0;
      if (out_valid[0] && out_ready) begin
        if (q.size() == 0) begin
          fail($sformatf("unexpected_output px%0d", out_idx));
        end else begin
          exp_t e;
          e = q.pop_front();
          for (int i = 0; i < N; i++) begin
            check($sformatf("px%0d_rgb_dut%0d", out_idx, i),
                  32'({out_red[i], out_green[i], out_blue[i]}), 32'(e.rgb[i]));
            check($sformatf("px%0d_eol_dut%0d", out_idx, i), 32'(out_eol[i]), 32'(e.eol));
          end
          fd_exp = (out_idx % (W * H) == W * H - 1);
          out_idx++;
        end
      end
      prev_stall = out_valid[0] && !out_ready;
      prev_out   = {out_valid[0], out_eol[0], out_red[0], out_green[0], out_blue[0]};
      if (in_valid && in_ready[0]) begin
        cur.eol = (in_idx % W == W - 1);
        q.push_back(cur);
        in_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int fd_before;
    // {r,g,b} -> {add100, sub100, invert, thr90, thr255}
    vecs[0] = mkv(200, 10, 155, px(255,110,255), px(100,0,55),  px(55,245,100),  '1, '0);
    vecs[1] = mkv(50, 100, 101, px(150,200,201), px(0,0,1),     px(205,155,154), '0, '0);
    vecs[2] = mkv(0, 128, 255,  px(100,228,255), px(0,28,155),  px(255,127,0),   '1, '0);
    vecs[3] = mkv(90, 90, 90,   px(190,190,190), px(0,0,0),     px(165,165,165), '0, '0);
    vecs[4] = mkv(90, 90, 91,   px(190,190,191), px(0,0,0),     px(165,165,164), '1, '0);
    vecs[5] = mkv(255,255,255,  px(255,255,255), px(155,155,155), px(0,0,0),     '1, '0);
    vecs[6] = mkv(0, 0, 0,      px(100,100,100), px(0,0,0),     px(255,255,255), '0, '0);
    vecs[7] = mkv(155, 156, 100, px(255,255,200), px(55,56,0),  px(100,99,155),  '1, '0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_red = '0; in_green = '0; in_blue = '0;
    cur = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_out_eol", 32'(out_eol), 0);
    for (int i = 0; i < N; i++)
      check($sformatf("rst_data_dut%0d", i), 32'({out_red[i], out_green[i], out_blue[i]}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'({N{1'b1}}));
    @(posedge clk); #1;

    // Two-cycle latency on a single pixel.
    send(vecs[0].r, vecs[0].g, vecs[0].b, vecs[0].rgb);
    @(negedge clk);
    check("latency_cycle1_valid", 32'(out_valid[0]), 0);
    @(negedge clk);
    check("latency_cycle2_valid", 32'(out_valid[0]), 1);
    @(posedge clk); #1;
    drain();

    // Table vectors, back-to-back.
    for (int i = 0; i < 8; i++) send(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].rgb);
    drain();

    // Backpressure: 10 pixels with a 5-cycle output stall in the middle.
    fork
      begin
        for (int k = 0; k < 10; k++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 2) check("in_ready_stalled", 32'(in_ready[0]), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two pixels in flight.
    send_rand();
    send_rand();
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 0);
    check("midreset_out_eol", 32'(out_eol), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // One full frame plus one pixel, back-to-back from position (0,0).
    fd_before = fd_pulses;
    for (int k = 0; k < W * H + 1; k++) send_rand();
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("frame_done_pulse_count", 32'(fd_pulses - fd_before), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
